// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter that hands a single AXI burst master to one of two
//   requesters, a writer and a reader. It copies the granted burst descriptor
//   to the master, watches the AXI completion handshake, and pulses done back
//   to the owning requester.
//
// Handshakes:
//   x_req is a level request. It stays high until x_ack pulses. x_ack, start_x
//   and x_done are one-cycle pulses. The completion inputs are sampled only in
//   the matching WAIT state:
//     - bvalid&bready ends a write.
//     - rvalid&rready&rlast ends a read.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   wr_req/rd_req            level requests
//   wr_addr/rd_addr, *_len   burst start address / beat count per requester
//   wr_ack/rd_ack            request accepted (GRANT cycle)
//   wr_done/rd_done          burst complete (or zero-length / watchdog abort)
//   start_write/start_read   kick to the burst master
//   write_addr/read_addr,
//   write_len/read_len       registered descriptor, held until the next grant
//   bvalid,bready,rvalid,
//   rready,rlast             monitored AXI completion signals
//   busy                     high in every state except IDLE
//   len_err                  granted burst had length 0
//   timeout                  watchdog expired (only with MEM_ARB_TIMEOUT_EN)
//   dbg_state                current FSM state for observation
//
// Configuration:
//   `define MEM_ARB_TIMEOUT_EN builds a 16-bit WAIT watchdog that uses
//   TIMEOUT_CYCLES as its limit. Without that macro, WAIT never times out and
//   timeout is held low.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [31:0]           wr_len,
  input  logic [31:0]           rd_len,
  output logic                  wr_ack,
  output logic                  rd_ack,
  output logic                  wr_done,
  output logic                  rd_done,
  output logic                  start_write,
  output logic                  start_read,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           write_len,
  output logic [31:0]           read_len,
  input  logic                  bvalid,
  input  logic                  bready,
  input  logic                  rvalid,
  input  logic                  rready,
  input  logic                  rlast,
  output logic                  busy,
  output logic                  len_err,
  output logic                  timeout,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_W = 3'd1,
    WAIT_W  = 3'd2,
    GRANT_R = 3'd3,
    WAIT_R  = 3'd4
  } state_e;

  localparam logic LG_WRITE = 1'b0;
  localparam logic LG_READ  = 1'b1;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  wr_done_q, wr_done_d;
  logic                  rd_done_q, rd_done_d;
  logic                  start_write_q, start_write_d;
  logic                  start_read_q, start_read_d;
  logic                  len_err_q, len_err_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic [31:0]           write_len_q, write_len_d;
  logic [31:0]           read_len_q, read_len_d;
  logic                  pick_w, pick_r;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic        timeout_q, timeout_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    wr_ack_d      = 1'b0;
    rd_ack_d      = 1'b0;
    wr_done_d     = 1'b0;
    rd_done_d     = 1'b0;
    start_write_d = 1'b0;
    start_read_d  = 1'b0;
    len_err_d     = 1'b0;
    write_addr_d  = write_addr_q;
    write_len_d   = write_len_q;
    read_addr_d   = read_addr_q;
    read_len_d    = read_len_q;
    pick_w        = 1'b0;
    pick_r        = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    timeout_d     = 1'b0;
    wd_cnt_d      = wd_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        // The IDLE cycle that carries a done pulse does not arbitrate. This
        // gives the finished requester one cycle to see done before its
        // still-high request is treated as a new one.
        if (!(wr_done_q || rd_done_q)) begin
          pick_w = wr_req && (!rd_req || (last_grant_q == LG_READ));
          pick_r = rd_req && !pick_w;
          if (pick_w) begin
            state_d      = GRANT_W;
            last_grant_d = LG_WRITE;
            wr_ack_d     = 1'b1;
            write_addr_d = wr_addr;
            write_len_d  = wr_len;
            // A zero-length burst is acked and completed in GRANT, never started.
            if (wr_len == 32'd0) begin
              len_err_d = 1'b1;
              wr_done_d = 1'b1;
            end else begin
              start_write_d = 1'b1;
            end
          end else if (pick_r) begin
            state_d      = GRANT_R;
            last_grant_d = LG_READ;
            rd_ack_d     = 1'b1;
            read_addr_d  = rd_addr;
            read_len_d   = rd_len;
            if (rd_len == 32'd0) begin
              len_err_d = 1'b1;
              rd_done_d = 1'b1;
            end else begin
              start_read_d = 1'b1;
            end
          end
        end
      end
      GRANT_W: begin
        state_d = (write_len_q == 32'd0) ? IDLE : WAIT_W;
`ifdef MEM_ARB_TIMEOUT_EN
        wd_cnt_d = 16'd0;
`endif
      end
      WAIT_W: begin
        if (bvalid && bready) begin
          wr_done_d = 1'b1;
          state_d   = IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Completion has priority over the watchdog in the same cycle.
        else if (wd_cnt_q == TO_LAST) begin
          wr_done_d = 1'b1;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
`endif
      end
      GRANT_R: begin
        state_d = (read_len_q == 32'd0) ? IDLE : WAIT_R;
`ifdef MEM_ARB_TIMEOUT_EN
        wd_cnt_d = 16'd0;
`endif
      end
      WAIT_R: begin
        if (rvalid && rready && rlast) begin
          rd_done_d = 1'b1;
          state_d   = IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (wd_cnt_q == TO_LAST) begin
          rd_done_d = 1'b1;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= LG_READ;
      wr_ack_q      <= 1'b0;
      rd_ack_q      <= 1'b0;
      wr_done_q     <= 1'b0;
      rd_done_q     <= 1'b0;
      start_write_q <= 1'b0;
      start_read_q  <= 1'b0;
      len_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      write_addr_q  <= '0;
      write_len_q   <= '0;
      read_addr_q   <= '0;
      read_len_q    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      timeout_q     <= 1'b0;
      wd_cnt_q      <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      wr_ack_q      <= wr_ack_d;
      rd_ack_q      <= rd_ack_d;
      wr_done_q     <= wr_done_d;
      rd_done_q     <= rd_done_d;
      start_write_q <= start_write_d;
      start_read_q  <= start_read_d;
      len_err_q     <= len_err_d;
      busy_q        <= busy_d;
      write_addr_q  <= write_addr_d;
      write_len_q   <= write_len_d;
      read_addr_q   <= read_addr_d;
      read_len_q    <= read_len_d;
`ifdef MEM_ARB_TIMEOUT_EN
      timeout_q     <= timeout_d;
      wd_cnt_q      <= wd_cnt_d;
`endif
    end
  end

  assign wr_ack      = wr_ack_q;
  assign rd_ack      = rd_ack_q;
  assign wr_done     = wr_done_q;
  assign rd_done     = rd_done_q;
  assign start_write = start_write_q;
  assign start_read  = start_read_q;
  assign len_err     = len_err_q;
  assign busy        = busy_q;
  assign write_addr  = write_addr_q;
  assign write_len   = write_len_q;
  assign read_addr   = read_addr_q;
  assign read_len    = read_len_q;
  assign dbg_state   = state_q;

`ifdef MEM_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  // No watchdog is built. The limit is referenced only so the parameter is
  // not left dangling, and the expression is constant zero.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
//
// Each expected output event is pushed into exp_q as
//   {cycle, pulses, write_addr, write_len, read_addr, read_len}
// A monitor pops and compares one entry whenever any pulse output is high.
//
// Pulse order:
//   start_write, wr_ack, wr_done, start_read, rd_ack, rd_done, len_err, timeout
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int EW = 16 + 8 + 4 * 32;

  localparam logic [7:0] P_SW = 8'h80;
  localparam logic [7:0] P_WA = 8'h40;
  localparam logic [7:0] P_WD = 8'h20;
  localparam logic [7:0] P_SR = 8'h10;
  localparam logic [7:0] P_RA = 8'h08;
  localparam logic [7:0] P_RD = 8'h04;
  localparam logic [7:0] P_LE = 8'h02;
  localparam logic [7:0] P_TO = 8'h01;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [31:0]   wr_len = '0, rd_len = '0;
  logic          bvalid = 1'b0, bready = 1'b0;
  logic          rvalid = 1'b0, rready = 1'b0, rlast = 1'b0;
  logic          wr_ack, rd_ack, wr_done, rd_done, start_write, start_read;
  logic [AW-1:0] write_addr, read_addr;
  logic [31:0]   write_len, read_len;
  logic          busy, len_err, timeout;
  logic [2:0]    dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .rd_req(rd_req),
    .wr_addr(wr_addr), .rd_addr(rd_addr),
    .wr_len(wr_len), .rd_len(rd_len),
    .wr_ack(wr_ack), .rd_ack(rd_ack),
    .wr_done(wr_done), .rd_done(rd_done),
    .start_write(start_write), .start_read(start_read),
    .write_addr(write_addr), .read_addr(read_addr),
    .write_len(write_len), .read_len(read_len),
    .bvalid(bvalid), .bready(bready),
    .rvalid(rvalid), .rready(rready), .rlast(rlast),
    .busy(busy), .len_err(len_err), .timeout(timeout),
    .dbg_state(dbg_state)
  );

  logic [15:0] cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   m_wa = '0, m_wl = '0, m_ra = '0, m_rl = '0;
  logic [7:0]    pulses;

  assign pulses = {start_write, wr_ack, wr_done, start_read, rd_ack, rd_done, len_err, timeout};

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] obs;
    obs = {cyc, pulses, write_addr, write_len, read_addr, read_len};
    if (pulses != 8'h00) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event act=%h req=none", obs);
      end else begin
        check("event", obs, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int off, input logic [7:0] p);
    exp_q.push_back({cyc + 16'(off), p, m_wa, m_wl, m_ra, m_rl});
  endtask

  task automatic set_b(input logic v);
    bvalid = v;
    bready = v;
  endtask

  task automatic set_r(input logic v, input logic last);
    rvalid = v;
    rready = v;
    rlast  = last;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_pulses"}, EW'(pulses), '0);
    check({name, "_busy"},   EW'(busy), '0);
    check({name, "_state"},  EW'(dbg_state), '0);
    check({name, "_addrs"},  EW'({write_addr, write_len, read_addr, read_len}), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(3);
    check_quiet("reset");
    rst = 1'b0;
    tick(1);

    // Single write: ack/start one cycle later, done one cycle after B.
    // Read completion signals during the write must be ignored.
    wr_addr = 32'h40; wr_len = 32'd8; wr_req = 1'b1;
    m_wa = 32'h40; m_wl = 32'd8; push_ev(1, P_SW | P_WA);
    tick(1);
    wr_req = 1'b0; set_r(1'b1, 1'b1);
    check("a_busy_grant", EW'(busy), EW'(1'b1));
    tick(2);
    set_r(1'b0, 1'b0); set_b(1'b1); push_ev(1, P_WD);
    tick(1);
    set_b(1'b0);
    check("a_busy_after_done", EW'(busy), EW'(1'b0));
    tick(2);

    // Reset clears the held descriptor and restores last_grant to READ.
    rst = 1'b1;
    #1;
    check_quiet("rst_async");
    tick(1);
    rst = 1'b0;
    m_wa = '0; m_wl = '0; m_ra = '0; m_rl = '0;
    tick(1);

    // Tie right after reset: writer first. Read starts 2 cycles after wr_done.
    wr_addr = 32'h100; wr_len = 32'd4; wr_req = 1'b1;
    rd_addr = 32'h200; rd_len = 32'd2; rd_req = 1'b1;
    m_wa = 32'h100; m_wl = 32'd4; push_ev(1, P_SW | P_WA);
    tick(1);
    wr_req = 1'b0;
    tick(2);
    set_b(1'b1); push_ev(1, P_WD);
    tick(1);
    set_b(1'b0);
    m_ra = 32'h200; m_rl = 32'd2; push_ev(2, P_SR | P_RA);
    tick(2);
    rd_req = 1'b0;
    tick(2);
    set_r(1'b1, 1'b0);          // a non-last beat must not end the read
    tick(1);
    rlast = 1'b1; push_ev(1, P_RD);
    tick(1);
    set_r(1'b0, 1'b0);
    tick(2);

    // Both held through three bursts: W, R, W.
    wr_addr = 32'h300; wr_len = 32'd1; wr_req = 1'b1;
    rd_addr = 32'h400; rd_len = 32'd3; rd_req = 1'b1;
    m_wa = 32'h300; m_wl = 32'd1; push_ev(1, P_SW | P_WA);
    tick(3);
    set_b(1'b1); push_ev(1, P_WD);
    tick(1);
    set_b(1'b0);
    m_ra = 32'h400; m_rl = 32'd3; push_ev(2, P_SR | P_RA);
    tick(4);
    set_r(1'b1, 1'b1); push_ev(1, P_RD);
    tick(1);
    set_r(1'b0, 1'b0); push_ev(2, P_SW | P_WA);
    tick(2);
    wr_req = 1'b0; rd_req = 1'b0;
    tick(2);
    set_b(1'b1); push_ev(1, P_WD);
    tick(1);
    set_b(1'b0);
    tick(2);

    // Zero-length read: ack, done and len_err together, no start, back to IDLE.
    rd_addr = 32'h500; rd_len = 32'd0; rd_req = 1'b1;
    m_ra = 32'h500; m_rl = 32'd0; push_ev(1, P_RA | P_RD | P_LE);
    tick(1);
    rd_req = 1'b0;
    check("d_busy_grant", EW'(busy), EW'(1'b1));
    tick(1);
    check("d_state_idle", EW'(dbg_state), EW'(3'd0));
    check("d_busy_idle", EW'(busy), EW'(1'b0));
    tick(2);

    // Reset during WAIT_R: no rd_done, outputs zero, next tie goes to the writer.
    // A write request dropped before being granted leaves no trace.
    rd_addr = 32'h600; rd_len = 32'd5; rd_req = 1'b1;
    m_ra = 32'h600; m_rl = 32'd5; push_ev(1, P_SR | P_RA);
    tick(1);
    rd_req = 1'b0; wr_addr = 32'hdead; wr_len = 32'd9; wr_req = 1'b1;
    tick(1);
    wr_req = 1'b0;
    check("e_state_wait_r", EW'(dbg_state), EW'(3'd4));
    tick(1);
    rst = 1'b1; set_r(1'b1, 1'b1);
    #1;
    check_quiet("e_rst_mid_burst");
    m_wa = '0; m_wl = '0; m_ra = '0; m_rl = '0;
    tick(1);
    rst = 1'b0; set_r(1'b0, 1'b0);
    tick(1);
    wr_addr = 32'h700; wr_len = 32'd2; wr_req = 1'b1;
    rd_addr = 32'h800; rd_len = 32'd2; rd_req = 1'b1;
    m_wa = 32'h700; m_wl = 32'd2; push_ev(1, P_SW | P_WA);
    tick(1);
    wr_req = 1'b0;
    tick(2);
    set_b(1'b1); push_ev(1, P_WD);
    tick(1);
    set_b(1'b0);
    m_ra = 32'h800; m_rl = 32'd2; push_ev(2, P_SR | P_RA);
    tick(2);
    rd_req = 1'b0;
    tick(2);
    set_r(1'b1, 1'b1); push_ev(1, P_RD);
    tick(1);
    set_r(1'b0, 1'b0);
    tick(2);

`ifdef MEM_ARB_TIMEOUT_EN
    // No rlast: watchdog ends the read 16 cycles after WAIT_R entry.
    rd_addr = 32'h900; rd_len = 32'd4; rd_req = 1'b1;
    m_ra = 32'h900; m_rl = 32'd4; push_ev(1, P_SR | P_RA);
    tick(1);
    rd_req = 1'b0; set_r(1'b1, 1'b0);
    tick(16);
    check("f_busy_before_to", EW'(busy), EW'(1'b1));
    push_ev(1, P_RD | P_TO);
    tick(1);
    check("f_busy_after_to", EW'(busy), EW'(1'b0));
    set_r(1'b0, 1'b0);
    tick(2);
`endif

    // ---------------- report ----------------
    tick(3);
    while (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL missing_event act=none req=%h", exp_q.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
